// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte types and the forward S-box constant.
// Imported by the SubBytes lane lookup and the SubBytes stage.
package aes_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [127:0] aes_state_t;

    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/sbox_lut.sv
// One AES forward S-box lane: pure combinational constant-ROM lookup.
module sbox_lut
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/sub_bytes.sv
// AES SubBytes stage: 16 independent S-box lanes followed by a single
// result/valid register giving one cycle of latency at full throughput.
module sub_bytes
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [127:0] input_block,
    output logic         out_valid,
    output logic [127:0] subbed_block
);

    aes_state_t sub_comb;

    for (genvar i = 0; i < 16; i++) begin : g_lane
        sbox_lut u_sbox (
            .in_byte  (input_block[8*i +: 8]),
            .out_byte (sub_comb[8*i +: 8])
        );
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            subbed_block <= '0;
            out_valid    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Idle cycles leave the last result visible for downstream debug.
            if (in_valid) begin
                subbed_block <= sub_comb;
            end
        end
    end

endmodule

// File: tb/tb_sub_bytes.sv
// Scoreboard bench for sub_bytes: the stimulus thread queues the expected
// register state per cycle, a monitor pops and compares 1 time unit after each edge.
module tb_sub_bytes;

    typedef struct {
        logic         valid;
        logic [127:0] data;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] input_block;
    logic         out_valid;
    logic [127:0] subbed_block;

    exp_t         sb_q[$];
    int           checks;
    int           errors;
    logic [7:0]   ref_tbl [256];

    sub_bytes dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .input_block  (input_block),
        .out_valid    (out_valid),
        .subbed_block (subbed_block)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: GF(2^8) multiplicative inverse plus the affine map.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_ref();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            ref_tbl[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                       ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %032h expected %032h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the register state expected after the edge.
    task automatic drive(input logic r, input logic v, input logic [127:0] d,
                         input logic ev, input logic [127:0] ed);
        exp_t e;
        @(negedge clk);
        rst         = r;
        in_valid    = v;
        input_block = d;
        e.valid = ev;
        e.data  = ed;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("out_valid", {127'h0, out_valid}, {127'h0, e.valid});
                check("subbed_block", subbed_block, e.data);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [127:0] blk;
        logic [127:0] exp_blk;
        logic [127:0] k_in;
        logic [127:0] k_out;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid = 1'b1;
        input_block = 128'hdeadbeef_01234567_89abcdef_55aa33cc;
        build_ref();

        // Reset wins over in_valid with live data.
        drive(1'b1, 1'b1, 128'hdeadbeef_01234567_89abcdef_55aa33cc, 1'b0, 128'h0);
        drive(1'b1, 1'b1, 128'hffffffff_00000000_12345678_9abcdef0, 1'b0, 128'h0);

        // Known vector, uniform bytes and the 00..0F ramp.
        k_in  = 128'h78419533EB3314D221B174E1C752B68E;
        k_out = 128'hBC832AC3E9C3FAB5FDC892F8C6004E19;
        drive(1'b0, 1'b1, k_in, 1'b1, k_out);
        drive(1'b0, 1'b1, 128'h0, 1'b1, {16{8'h63}});
        drive(1'b0, 1'b1, {16{8'hff}}, 1'b1, {16{8'h16}});
        drive(1'b0, 1'b1, 128'h0F0E0D0C0B0A09080706050403020100, 1'b1,
              128'h76ABD7FE2B670130C56F6BF27B777C63);

        // Three back-to-back blocks, then two idle cycles holding the third.
        drive(1'b0, 1'b1, {16{8'h01}}, 1'b1, {16{8'h7c}});
        drive(1'b0, 1'b1, {16{8'h53}}, 1'b1, {16{8'hed}});
        drive(1'b0, 1'b1, k_in, 1'b1, k_out);
        drive(1'b0, 1'b0, 128'h0, 1'b0, k_out);
        drive(1'b0, 1'b0, {16{8'h01}}, 1'b0, k_out);

        // Reset right after a valid input discards it; next valid has 1-cycle latency.
        drive(1'b0, 1'b1, {16{8'h53}}, 1'b1, {16{8'hed}});
        drive(1'b1, 1'b1, k_in, 1'b0, 128'h0);
        drive(1'b0, 1'b0, k_in, 1'b0, 128'h0);
        drive(1'b0, 1'b1, k_in, 1'b1, k_out);

        // Every value through every lane, with a distinct value per lane each cycle.
        for (int v = 0; v < 256; v++) begin
            for (int i = 0; i < 16; i++) begin
                blk[8*i +: 8]     = 8'(v + 17 * i);
                exp_blk[8*i +: 8] = ref_tbl[8'(v + 17 * i)];
            end
            drive(1'b0, 1'b1, blk, 1'b1, exp_blk);
        end
        drive(1'b0, 1'b0, 128'h0, 1'b0, exp_blk);

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected results left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sub_bytes.md
# sub_bytes

AES SubBytes stage: applies the FIPS-197 forward S-box independently to each of the 16 bytes of a 128-bit state block. It sits in the AES round datapath between the AddRoundKey output and ShiftRows. It is registered with one cycle of latency so that the round pipeline has a defined register boundary.

## Interface
Parameters: none. The block is fixed at 128-bit AES state and 8-bit S-box.

Ports:
- clk  in  1  — system clock; all state updates on rising edge.
- rst  in  1  — reset, synchronous and active-high; sampled on rising edge of clk.
- in_valid  in  1  — input_block carries a valid state this cycle.
- input_block  in  128  — state to substitute; byte i = bits [8i+7:8i].
- out_valid  out  1  — subbed_block holds a valid result.
- subbed_block  out  128  — substituted state; byte i = S(input byte i).

## Operation
- Per byte: subbed_block[8i+7:8i] = SBOX[input_block[8i+7:8i]], for i = 0..15.
- SBOX is the standard AES forward S-box (256 entries, no inverse).
  - Spot values: SBOX[00]=63, SBOX[01]=7C, SBOX[53]=ED, SBOX[FF]=16.
- Bytes are fully independent: there is no mixing, ordering change or carry between byte lanes.
- On a rising edge with rst=0 and in_valid=1:
  - subbed_block ← substituted input_block.
  - out_valid ← 1.
- On a rising edge with rst=0 and in_valid=0:
  - out_valid ← 0.
  - subbed_block holds its previous value.
- No backpressure exists; the block accepts one block per cycle unconditionally.
- The S-box lookup is pure combinational logic (256-way case or constant ROM). No RAM and no clock-gating.

## Timing
- Reset: on a rising edge with rst=1, subbed_block ← 128'h0 and out_valid ← 0. rst has priority over in_valid.
- Latency: exactly 1 cycle. Input sampled at edge N appears on subbed_block/out_valid after edge N.
- Throughput: 1 block/cycle. Back-to-back valid inputs produce back-to-back valid outputs.
- Reset asserted mid-stream: the in-flight result is discarded. The first cycle after rst is released shows out_valid=0.
- in_valid deasserted for a gap: the output value is frozen and out_valid=0 for each idle cycle.
- No X propagation requirement beyond normal RTL behaviour. Outputs are defined after the first reset.

## Structure
- Shared package aes_pkg holds:
  - localparam SBOX: 256×8 forward S-box constant.
  - typedef aes_state_t: logic [127:0].
  - typedef aes_byte_t: logic [7:0].
- One sub-module, sbox_lut: 8-bit in, 8-bit out, combinational lookup from aes_pkg::SBOX.
- sub_bytes instantiates sbox_lut 16 times via generate and adds the output/valid register.
- The inverse S-box is out of scope for this block.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1 and arbitrary data -> subbed_block=0, out_valid=0.
- Known vector: input_block=128'h78419533EB3314D221B174E1C752B68E, in_valid=1 -> one cycle later subbed_block=128'hBC832AC3E9C3FAB5FDC892F8C6004E19, out_valid=1.
- Uniform bytes:
  - all-00 -> 128'h6363…63 (16×63).
  - all-FF -> 16×16.
  - byte pattern 0x00..0x0F (byte0=00) -> byte-wise 63,7C,77,7B,F2,6B,6F,C5,30,01,67,2B,FE,D7,AB,76.
- Exhaustive lane check: sweep all 256 values through each of the 16 lanes against a reference S-box model -> zero mismatches, with no cross-lane effects.
- Streaming and gaps: 3 consecutive valid blocks, then 2 idle cycles -> 3 consecutive out_valid=1 results in order, then out_valid=0 with subbed_block held at the 3rd result.
- Reset mid-stream: assert rst in the cycle after a valid input -> next output is 0/out_valid=0. The first valid input after release appears with 1-cycle latency.
